// File: rtl/sad_row_acc.sv
// rtl/sad_row_acc.sv - per-row SAD accumulation over a block with best-candidate tracking
module sad_row_acc #(
    parameter int PIX_W  = 8,
    parameter int NPIX   = 8,
    parameter int ROWS   = 16,
    parameter int NCAND  = 9,
    parameter int CAND_W = 4,
    parameter int SAD_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [NPIX*PIX_W-1:0]   i_cur_row,
    input  logic [NPIX*PIX_W-1:0]   i_ref_row,
    input  logic                    i_row_valid,
    output logic                    o_busy,
    output logic                    o_sad_valid,
    output logic [SAD_W-1:0]        o_sad,
    output logic [CAND_W-1:0]       o_cand_idx,
    output logic                    o_best_valid,
    output logic [SAD_W-1:0]        o_best_sad,
    output logic [CAND_W-1:0]       o_best_idx
);
    localparam int RSUM_W = PIX_W + $clog2(NPIX);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                     r_state;
    logic [ROW_W-1:0]               r_row_cnt;
    logic [CAND_W-1:0]              r_cand_cnt;

    logic                           r_s1_valid, r_s1_first, r_s1_last;
    logic [CAND_W-1:0]              r_s1_cand;
    logic [NPIX-1:0][PIX_W-1:0]     r_s1_diff;

    logic                           r_s2_valid, r_s2_first, r_s2_last;
    logic [CAND_W-1:0]              r_s2_cand;
    logic [RSUM_W-1:0]              r_s2_sum;

    logic [SAD_W-1:0]               r_acc;

    logic                           w_accept, w_row_last, w_cand_last, w_final_cmp, w_better;
    logic [NPIX-1:0][PIX_W-1:0]     w_diff;
    logic [RSUM_W-1:0]              w_row_sum;
    logic [SAD_W-1:0]               w_acc_next;

    assign w_accept    = (r_state == ST_RUN) && i_row_valid;
    assign w_row_last  = (r_row_cnt == ROW_W'(ROWS - 1));
    assign w_cand_last = (r_cand_cnt == CAND_W'(NCAND - 1));
    // The last candidate's sad_valid is the only one that can land while flushing.
    assign w_final_cmp = (r_state == ST_FLUSH) && o_sad_valid;
    assign w_better    = (o_sad < o_best_sad);
    assign w_acc_next  = r_s2_first ? SAD_W'(r_s2_sum) : r_acc + SAD_W'(r_s2_sum);

    always_comb begin
        w_diff = '0;
        for (int k = 0; k < NPIX; k++) begin
            if (i_cur_row[k*PIX_W +: PIX_W] > i_ref_row[k*PIX_W +: PIX_W])
                w_diff[k] = i_cur_row[k*PIX_W +: PIX_W] - i_ref_row[k*PIX_W +: PIX_W];
            else
                w_diff[k] = i_ref_row[k*PIX_W +: PIX_W] - i_cur_row[k*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        w_row_sum = '0;
        for (int k = 0; k < NPIX; k++)
            w_row_sum = w_row_sum + RSUM_W'(r_s1_diff[k]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_row_cnt  <= '0;
            r_cand_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_state    <= ST_RUN;
                    r_row_cnt  <= '0;
                    r_cand_cnt <= '0;
                end
                ST_RUN: if (w_accept) begin
                    if (w_row_last) begin
                        r_row_cnt <= '0;
                        if (w_cand_last) r_state    <= ST_FLUSH;
                        else             r_cand_cnt <= r_cand_cnt + CAND_W'(1);
                    end else begin
                        r_row_cnt <= r_row_cnt + ROW_W'(1);
                    end
                end
                ST_FLUSH: if (w_final_cmp) r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cand  <= '0;
            r_s1_diff  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_cand  <= '0;
            r_s2_sum   <= '0;
            r_acc      <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_diff  <= w_diff;
                r_s1_first <= (r_row_cnt == '0);
                r_s1_last  <= w_row_last;
                r_s1_cand  <= r_cand_cnt;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sum   <= w_row_sum;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
                r_s2_cand  <= r_s1_cand;
            end
            if (r_s2_valid) r_acc <= w_acc_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sad_valid  <= 1'b0;
            o_sad        <= '0;
            o_cand_idx   <= '0;
            o_best_valid <= 1'b0;
            o_best_sad   <= '0;
            o_best_idx   <= '0;
            o_busy       <= 1'b0;
        end else begin
            o_sad_valid <= r_s2_valid && r_s2_last;
            if (r_s2_valid && r_s2_last) begin
                o_sad      <= w_acc_next;
                o_cand_idx <= r_s2_cand;
            end
            o_best_valid <= w_final_cmp;
            if ((r_state == ST_IDLE) && i_start) begin
                o_best_sad <= '1;
                o_best_idx <= '0;
                o_busy     <= 1'b1;
            end else begin
                // Strict compare: a tie keeps the earlier candidate.
                if (o_sad_valid && w_better) begin
                    o_best_sad <= o_sad;
                    o_best_idx <= o_cand_idx;
                end
                if (w_final_cmp) o_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sad_row_acc.sv
// tb/tb_sad_row_acc.sv - self-checking bench for sad_row_acc
module tb_sad_row_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        row_valid = 1'b0;
    logic [63:0] cur = '0;
    logic [63:0] refr = '0;
    logic        o_busy, o_sad_valid, o_best_valid;
    logic [15:0] o_sad, o_best_sad;
    logic [3:0]  o_cand_idx, o_best_idx;

    sad_row_acc dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_cur_row(cur), .i_ref_row(refr), .i_row_valid(row_valid),
        .o_busy(o_busy), .o_sad_valid(o_sad_valid), .o_sad(o_sad), .o_cand_idx(o_cand_idx),
        .o_best_valid(o_best_valid), .o_best_sad(o_best_sad), .o_best_idx(o_best_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int q_due[$], q_sad[$], q_idx[$];
    int b_due[$], b_sad[$], b_idx[$];
    logic [15:0] dut_sad [0:15];
    int d3 [9] = '{5, 3, 7, 3, 9, 2, 2, 8, 4};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hash(input int t, input int c, input int r);
        logic [63:0] h;
        h = 64'(c * 131 + r * 17 + t * 7 + 1) * 64'h9E3779B97F4A7C15;
        return h ^ (h >> 29);
    endfunction

    function automatic logic [63:0] mk_cur(input int t, input int c, input int r);
        case (t)
            1: return 64'h0;
            2: return (c % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h3010_3010_3010_3010;
            3: return {8{8'(d3[c])}};
            default: return hash(t, c, r);
        endcase
    endfunction

    function automatic logic [63:0] mk_ref(input int t, input int c, input int r);
        case (t)
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return (c % 2 == 0) ? 64'h0 : 64'h1030_1030_1030_1030;
            3: return 64'h0;
            default: return hash(t + 100, c, r);
        endcase
    endfunction

    function automatic int row_sad(input logic [63:0] a, input logic [63:0] b);
        int s = 0;
        for (int k = 0; k < 8; k++) begin
            int d = int'(a[8*k +: 8]) - int'(b[8*k +: 8]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_sad_valid) begin
                if (q_due.size() == 0) check("spurious_sad_valid", 1, 0);
                else begin
                    check("sad_timing", cyc, q_due[0]);
                    check("sad", o_sad, q_sad[0]);
                    check("cand_idx", o_cand_idx, q_idx[0]);
                    dut_sad[o_cand_idx] = o_sad;
                    void'(q_due.pop_front()); void'(q_sad.pop_front()); void'(q_idx.pop_front());
                end
            end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
                check("sad_valid_missing", 0, 1);
                void'(q_due.pop_front()); void'(q_sad.pop_front()); void'(q_idx.pop_front());
            end
            if (o_best_valid) begin
                if (b_due.size() == 0) check("spurious_best_valid", 1, 0);
                else begin
                    check("best_timing", cyc, b_due[0]);
                    check("best_sad", o_best_sad, b_sad[0]);
                    check("best_idx", o_best_idx, b_idx[0]);
                    check("busy_at_best", o_busy, 0);
                    void'(b_due.pop_front()); void'(b_sad.pop_front()); void'(b_idx.pop_front());
                end
            end else if (b_due.size() > 0 && b_due[0] <= cyc) begin
                check("best_valid_missing", 0, 1);
                void'(b_due.pop_front()); void'(b_sad.pop_front()); void'(b_idx.pop_front());
            end
        end
    end

    task automatic run_search(input int t, input bit gaps, input int stop_c, input int stop_r);
        int acc, best, bidx, last_due;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", o_busy, 1);
        best = 16'hFFFF; bidx = 0; last_due = 0;
        for (int c = 0; c < 9; c++) begin
            acc = 0;
            for (int r = 0; r < 16; r++) begin
                if (c == stop_c && r == stop_r) return;
                if (gaps) begin
                    row_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                if (t == 5 && c == 2 && r == 3) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                cur = mk_cur(t, c, r);
                refr = mk_ref(t, c, r);
                row_valid = 1'b1;
                @(posedge clk); #1;
                row_valid = 1'b0;
                acc += row_sad(cur, refr);
                if (r == 15) begin
                    last_due = cyc + 2;
                    q_due.push_back(last_due); q_sad.push_back(acc); q_idx.push_back(c);
                    if (acc < best) begin best = acc; bidx = c; end
                end
            end
        end
        b_due.push_back(last_due + 1); b_sad.push_back(best); b_idx.push_back(bidx);
        if (t == 5) begin
            cur = '1; refr = '0; row_valid = 1'b1;
            @(posedge clk); @(posedge clk); #1;
            row_valid = 1'b0;
        end
        for (int i = 0; i < 40 && (q_due.size() + b_due.size()) > 0; i++) @(posedge clk);
        #1;
        if ((q_due.size() + b_due.size()) > 0) begin
            check("search_timeout", 0, 1);
            q_due.delete(); q_sad.delete(); q_idx.delete();
            b_due.delete(); b_sad.delete(); b_idx.delete();
        end
        check("busy_after_done", o_busy, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs", {o_busy, o_sad_valid, o_sad, o_cand_idx, o_best_valid, o_best_sad, o_best_idx}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_search(1, 1'b0, -1, -1);
        check("t1_sad", o_sad, 16'h7F80);
        check("t1_cand_idx", o_cand_idx, 8);
        check("t1_best_sad", o_best_sad, 16'h7F80);
        check("t1_best_idx", o_best_idx, 0);

        run_search(2, 1'b0, -1, -1);
        check("t2_swapped_sad", dut_sad[0], 16'h7F80);
        check("t2_alt_sad", dut_sad[1], 16'h1000);

        run_search(3, 1'b0, -1, -1);
        check("t3_best_sad", o_best_sad, 16'd256);
        check("t3_best_idx", o_best_idx, 5);
        check("t3_tie_sad", dut_sad[6], 16'd256);
        check("t3_sad4", dut_sad[4], 16'd1152);

        run_search(4, 1'b1, -1, -1);

        cur = hash(9, 9, 9); refr = '0; row_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 row_valid = 1'b0;
        check("idle_rows_ignored", o_busy, 0);
        run_search(5, 1'b0, -1, -1);

        run_search(6, 1'b0, 4, 7);
        #2 rst_n = 1'b0;
        #1;
        check("midsearch_reset_outputs", {o_busy, o_sad_valid, o_sad, o_cand_idx, o_best_valid, o_best_sad, o_best_idx}, 0);
        q_due.delete(); q_sad.delete(); q_idx.delete();
        b_due.delete(); b_sad.delete(); b_idx.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_search(6, 1'b0, -1, -1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
